// File: rtl/load_hazard_scoreboard_if.sv
// Pipeline-side signal bundle for the load-use hazard scoreboard.
// The master drives the IF/ID, ID/EXE and memory status; the slave returns stall controls.
interface load_hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] ifid_rs1;
    logic [REG_W-1:0] ifid_rs2;
    logic             ifid_rs1_used;
    logic             ifid_rs2_used;
    logic [REG_W-1:0] idexe_rd;
    logic             idexe_memread;
    logic             mem_ready;
    logic             branch_flush;
    logic             if_redo;
    logic             id_redo;
    logic             exe_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
        output idexe_rd, idexe_memread, mem_ready, branch_flush,
        input  if_redo, id_redo, exe_flush, busy, stall_cycles
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
        input  idexe_rd, idexe_memread, mem_ready, branch_flush,
        output if_redo, id_redo, exe_flush, busy, stall_cycles
    );
endinterface

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard controller: detects a dependent instruction behind a load, holds IF/ID
// for LOAD_LAT cycles and until memory is ready, honours branch flushes, counts stall cycles.
module load_hazard_scoreboard #(
    parameter int REG_W         = 5,
    parameter int LOAD_LAT      = 1,
    parameter int ZERO_REG_SAFE = 1,
    parameter int CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    load_hazard_scoreboard_if.slave     bus
);
    localparam int CW = $clog2(LOAD_LAT) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic             rdy_seen;
    logic [CNT_W-1:0] stall_cycles;

    logic rs_hit;
    logic rd_zero_block;
    logic match;
    logic done;
    logic stall;

    always_comb begin
        rs_hit = (bus.ifid_rs1_used && (bus.ifid_rs1 == bus.idexe_rd)) ||
                 (bus.ifid_rs2_used && (bus.ifid_rs2 == bus.idexe_rd));
        rd_zero_block = (ZERO_REG_SAFE != 0) && (bus.idexe_rd == '0);
        match = bus.idexe_memread && rs_hit && !rd_zero_block && !bus.branch_flush;
        done  = (cnt == '0) && (bus.mem_ready || rdy_seen);
        stall = 1'b0;
        if (state == IDLE) begin
            stall = match;
        end else begin
            stall = !done && !bus.branch_flush;
        end
    end

    // Gating with rst_n makes the stall outputs drop the instant reset asserts,
    // even though IDLE would otherwise pass a live match straight through.
    assign bus.if_redo      = stall && rst_n;
    assign bus.id_redo      = stall && rst_n;
    assign bus.exe_flush    = stall && rst_n;
    assign bus.busy         = (state == STALL) && rst_n;
    assign bus.stall_cycles = stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rdy_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state    <= STALL;
                        cnt      <= CW'(LOAD_LAT - 1);
                        rdy_seen <= 1'b0;
                    end else begin
                        cnt      <= '0;
                        rdy_seen <= 1'b0;
                    end
                end
                default: begin
                    if (bus.branch_flush || done) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        rdy_seen <= 1'b0;
                    end else begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                        rdy_seen <= rdy_seen | bus.mem_ready;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: doc/load_hazard_scoreboard.md
# load_hazard_scoreboard

Parametrised load-use hazard controller for the pipelined RISC-V core, sitting between the ID and EXE stages. It detects a dependent instruction in IF/ID that sources a load still in ID/EXE, stalls IF and ID, and injects bubbles into EXE. Unlike a purely combinational detector, it holds the stall for a configurable load-to-use latency and until the data memory reports ready. It also honours branch flushes and counts stall cycles for performance monitoring.

## Interface
- REG_W, 5, register-index width
- LOAD_LAT, 1, minimum stall cycles per load-use hazard (legal 1..8); 1 = classic 5-stage
- ZERO_REG_SAFE, 1, when 1 a source/dest index of 0 never creates a hazard
- CNT_W, 32, stall-cycle counter width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs1  in  REG_W  source 1 of instruction in IF/ID
- ifid_rs2  in  REG_W  source 2 of instruction in IF/ID
- ifid_rs1_used  in  1  instruction actually reads rs1
- ifid_rs2_used  in  1  instruction actually reads rs2
- idexe_rd  in  REG_W  destination of instruction in ID/EXE
- idexe_memread  in  1  instruction in ID/EXE is a load
- mem_ready  in  1  data memory has load data for the instruction in MEM
- branch_flush  in  1  IF/ID instruction is being killed this cycle
- if_redo  out  1  hold PC / IF stage
- id_redo  out  1  hold IF/ID register
- exe_flush  out  1  insert bubble into ID/EXE
- busy  out  1  FSM in STALL
- stall_cycles  out  CNT_W  cycles with if_redo=1, wraps modulo 2^CNT_W

## Operation
- Combinational `match` when all of the following hold:
  - idexe_memread
  - (ifid_rs1_used && rs1==rd) || (ifid_rs2_used && rs2==rd)
  - !(ZERO_REG_SAFE && rd==0)
  - !branch_flush
- The three stall outputs are always equal; this value is called `stall`.
- FSM states: IDLE, STALL. Registers: `cnt` (width $clog2(LOAD_LAT)+1), `rdy_seen`.
- IDLE:
  - stall = match.
  - On match: go to STALL, cnt <= LOAD_LAT-1, rdy_seen <= 0.
- STALL: ID/EXE holds a bubble, so no new detection occurs.
  - done = (cnt==0) && (mem_ready || rdy_seen).
  - stall = !done && !branch_flush.
  - If branch_flush: go to IDLE. The dependent instruction is dead; the pipeline's own flush takes over.
  - Else if done: go to IDLE.
  - Else: cnt decrements if >0; rdy_seen <= rdy_seen | mem_ready.
- Entering IDLE clears cnt and rdy_seen.
- busy = (state==STALL).
- stall_cycles increments by 1 on every edge where stall=1 and rst_n=1. It wraps from all-ones to 0.

## Timing
- Reset while rst_n=0, regardless of inputs:
  - State IDLE; cnt, rdy_seen and stall_cycles = 0.
  - if_redo, id_redo, exe_flush and busy are forced to 0.
- Reset mid-stall: outputs drop immediately (asynchronously); after release, the FSM is in IDLE.
- Detection latency is 0: stall asserts in the same cycle match goes high.
- With mem_ready held at 1, a hazard produces exactly LOAD_LAT stall cycles:
  - cycle t is the detection cycle;
  - cycles t+1 .. t+LOAD_LAT-1 are in STALL;
  - release occurs combinationally in STALL when cnt==0.
- mem_ready low extends the stall:
  - Release happens in the first STALL cycle where cnt==0 and mem_ready has been seen high (in that cycle or an earlier STALL cycle).
  - LOAD_LAT=1 with mem_ready low at t+1: stall continues until mem_ready is high.
- The stall output in STALL depends combinationally on mem_ready and branch_flush.
- branch_flush has priority over match and over a pending stall, in the same cycle.
- Back-to-back: after release, a new match in the following IDLE cycle starts a fresh stall with no dead cycle.

## Test plan
- LOAD_LAT=1, mem_ready=1, load rd=5, dependent instruction rs1=5 used.
  - Expect 1 stall cycle; busy=1 for 1 cycle; stall_cycles=1.
- LOAD_LAT=3, mem_ready=1, rd=7 matches rs2.
  - Expect stall at t, t+1, t+2; release at t+2 edge; stall_cycles=3.
- LOAD_LAT=1 with mem_ready low for 4 cycles after detection.
  - Expect stall for 5 cycles total; it drops in the cycle mem_ready rises.
- Non-hazard cases each produce stall=0 and stall_cycles unchanged:
  - rd=0 with rs1=0 (ZERO_REG_SAFE=1);
  - rs1 match but rs1_used=0;
  - match with branch_flush=1.
- LOAD_LAT=4, hazard, then branch_flush at t+2.
  - Expect stall=0 at t+2; IDLE next; stall_cycles=2.
- Edge cases:
  - Assert rst_n=0 mid-stall: outputs go to 0 immediately; counter and FSM clear.
  - Preload stall_cycles to 2^32-1 via a forced stall: it wraps to 0.
